// File: rtl/program_memory_arbiter_pkg.sv
// program_memory_arbiter_pkg: state and requester encodings shared by the
// arbiter top, its round-robin sub-block and the bus interface.
// PMEM_WORD_ADDR(addr, aw) slices a byte address down to its word index;
// bits [1:0] are dropped and bits above aw+1 fall off, so addresses wrap.

`ifndef PMEM_WORD_ADDR
`define PMEM_WORD_ADDR(addr, aw) addr[(aw)+1:2]
`endif

package program_memory_arbiter_pkg;

    typedef enum logic [1:0] {
        SHARED    = 2'd0,
        LOCK_PEND = 2'd1,
        LOCKED    = 2'd2
    } arb_state_t;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_LOAD  = 1'b1;

endpackage

// File: rtl/program_memory_arbiter_if.sv
// program_memory_arbiter_if: fetch, loader and memory-side signals of the
// program memory arbiter. The slave modport is the arbiter's view, the master
// modport the surrounding system's view.
// With PMEM_ARB_MISALIGN_TRAP_EN defined the interface also carries err_o.

interface program_memory_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  fetch_req_i;
    logic [DATA_WIDTH-1:0] fetch_addr_i;
    logic                  fetch_gnt_o;
    logic                  fetch_rvalid_o;
    logic [DATA_WIDTH-1:0] fetch_rdata_o;

    logic                  load_req_i;
    logic                  load_we_i;
    logic [DATA_WIDTH-1:0] load_addr_i;
    logic [DATA_WIDTH-1:0] load_wdata_i;
    logic                  load_lock_i;
    logic                  load_gnt_o;
    logic                  load_rvalid_o;
    logic [DATA_WIDTH-1:0] load_rdata_o;

    logic                  core_stall_o;

    logic                  mem_en_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

`ifdef PMEM_ARB_MISALIGN_TRAP_EN
    logic                  err_o;
`endif

    modport slave (
`ifdef PMEM_ARB_MISALIGN_TRAP_EN
        output err_o,
`endif
        input  fetch_req_i, fetch_addr_i,
        output fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
        input  load_req_i, load_we_i, load_addr_i, load_wdata_i, load_lock_i,
        output load_gnt_o, load_rvalid_o, load_rdata_o,
        output core_stall_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
`ifdef PMEM_ARB_MISALIGN_TRAP_EN
        input  err_o,
`endif
        output fetch_req_i, fetch_addr_i,
        input  fetch_gnt_o, fetch_rvalid_o, fetch_rdata_o,
        output load_req_i, load_we_i, load_addr_i, load_wdata_i, load_lock_i,
        input  load_gnt_o, load_rvalid_o, load_rdata_o,
        input  core_stall_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );

endinterface

// File: rtl/program_memory_arbiter_rr_arbiter_2.sv
// program_memory_arbiter_rr_arbiter_2: two-input round-robin grant logic.
// A lone requester always wins; on a tie the requester that did not win the
// previous grant goes first. last_grant resets to fetch so the loader wins
// the first tie.

module program_memory_arbiter_rr_arbiter_2
    import program_memory_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_grant;

    // Pick the lone requester, or on a tie the one that lost last time.
    always_comb begin
        gnt = 2'b00;
        if (req[REQ_FETCH] && req[REQ_LOAD]) begin
            if (last_grant == REQ_FETCH) begin
                gnt[REQ_LOAD] = 1'b1;
            end else begin
                gnt[REQ_FETCH] = 1'b1;
            end
        end else begin
            gnt = req;
        end
    end

    // Remember the winner of every granted cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= REQ_FETCH;
        end else if (|gnt) begin
            last_grant <= gnt[REQ_LOAD] ? REQ_LOAD : REQ_FETCH;
        end
    end

endmodule

// File: rtl/program_memory_arbiter.sv
// program_memory_arbiter: shares a single-port, synchronous-read program
// memory between the core fetch port and the boot/debug loader.
// Grants are combinational; read data comes back one cycle after the grant
// and is steered to the requester that owns the pending read.
// Optional build macro PMEM_ARB_MISALIGN_TRAP_EN: misaligned or out-of-range
// accesses are granted but never reach the memory; they return zero data and
// pulse err_o one cycle later.
//
// state     | meaning
// ----------+-----------------------------------------------
// SHARED    | round-robin between fetch and loader
// LOCK_PEND | lock requested, letting the in-flight read drain
// LOCKED    | loader owns the memory exclusively

module program_memory_arbiter
    import program_memory_arbiter_pkg::*;
#(
    parameter int MEMORY_DEPTH = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5
) (
    input logic                     clk,
    input logic                     reset,
    program_memory_arbiter_if.slave bus
);

    arb_state_t            state;
    logic [1:0]            req;
    logic [1:0]            gnt;
    logic                  fetch_gnt;
    logic                  load_gnt;
    logic                  any_gnt;
    logic                  rd_issue;
    logic                  fetch_bad;
    logic                  load_bad;
    logic                  sel_bad;
    logic [ADDR_WIDTH-1:0] fetch_waddr;
    logic [ADDR_WIDTH-1:0] load_waddr;
    logic                  rd_pend;
    logic                  rd_owner;
    logic                  err_q;
    logic                  fetch_rvalid;
    logic                  load_rvalid;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [DATA_WIDTH-1:0] fetch_rdata_q;
    logic [DATA_WIDTH-1:0] load_rdata_q;
    logic [31:0]           unused_cfg;

    // Fetch is shut out whenever the loader holds or is acquiring the lock.
    assign req[REQ_FETCH] = bus.fetch_req_i & (state == SHARED) & ~reset;
    assign req[REQ_LOAD]  = bus.load_req_i & ~reset;

    program_memory_arbiter_rr_arbiter_2 u_rr_arbiter_2 (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .gnt   (gnt)
    );

    assign fetch_gnt = gnt[REQ_FETCH];
    assign load_gnt  = gnt[REQ_LOAD];
    assign any_gnt   = fetch_gnt | load_gnt;
    assign rd_issue  = fetch_gnt | (load_gnt & ~bus.load_we_i);

    assign fetch_waddr = `PMEM_WORD_ADDR(bus.fetch_addr_i, ADDR_WIDTH);
    assign load_waddr  = `PMEM_WORD_ADDR(bus.load_addr_i, ADDR_WIDTH);
    assign unused_cfg  = MEMORY_DEPTH;

`ifdef PMEM_ARB_MISALIGN_TRAP_EN
    assign fetch_bad = (|bus.fetch_addr_i[1:0]) | ((bus.fetch_addr_i >> (ADDR_WIDTH + 2)) != '0);
    assign load_bad  = (|bus.load_addr_i[1:0]) | ((bus.load_addr_i >> (ADDR_WIDTH + 2)) != '0);
    assign bus.err_o = err_q & ~reset;
`else
    logic unused_addr_bits;
    assign fetch_bad = 1'b0;
    assign load_bad  = 1'b0;
    assign unused_addr_bits = ^{bus.fetch_addr_i[DATA_WIDTH-1:ADDR_WIDTH+2], bus.fetch_addr_i[1:0],
                                bus.load_addr_i[DATA_WIDTH-1:ADDR_WIDTH+2], bus.load_addr_i[1:0]};
`endif

    assign sel_bad = (fetch_gnt & fetch_bad) | (load_gnt & load_bad);

    assign bus.fetch_gnt_o  = fetch_gnt;
    assign bus.load_gnt_o   = load_gnt;
    assign bus.mem_en_o     = any_gnt & ~sel_bad;
    assign bus.mem_we_o     = load_gnt & bus.load_we_i & ~sel_bad;
    assign bus.mem_addr_o   = load_gnt ? load_waddr : (fetch_gnt ? fetch_waddr : '0);
    assign bus.mem_wdata_o  = load_gnt ? bus.load_wdata_i : '0;
    assign bus.core_stall_o = ~reset & ((bus.fetch_req_i & ~fetch_gnt) | (state != SHARED));

    // A trapped access never touched the memory, so its response is zero.
    assign resp_data    = err_q ? '0 : bus.mem_rdata_i;
    assign fetch_rvalid = rd_pend & (rd_owner == REQ_FETCH) & ~reset;
    assign load_rvalid  = rd_pend & (rd_owner == REQ_LOAD) & ~reset;

    assign bus.fetch_rvalid_o = fetch_rvalid;
    assign bus.load_rvalid_o  = load_rvalid;
    assign bus.fetch_rdata_o  = fetch_rvalid ? resp_data : fetch_rdata_q;
    assign bus.load_rdata_o   = load_rvalid ? resp_data : load_rdata_q;

    // Lock sequencing: the pending-drain step always lasts a single cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SHARED;
        end else begin
            case (state)
                SHARED:    if (bus.load_lock_i) state <= LOCK_PEND;
                LOCK_PEND: state <= bus.load_lock_i ? LOCKED : SHARED;
                LOCKED:    if (!bus.load_lock_i) state <= SHARED;
                default:   state <= SHARED;
            endcase
        end
    end

    // Track the owner of the in-flight read and hold each port's last data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend       <= 1'b0;
            rd_owner      <= REQ_FETCH;
            err_q         <= 1'b0;
            fetch_rdata_q <= '0;
            load_rdata_q  <= '0;
        end else begin
            rd_pend       <= rd_issue;
            rd_owner      <= load_gnt ? REQ_LOAD : REQ_FETCH;
            err_q         <= any_gnt & sel_bad;
            fetch_rdata_q <= bus.fetch_rdata_o;
            load_rdata_q  <= bus.load_rdata_o;
        end
    end

endmodule

// File: doc/program_memory_arbiter.md
Name: program_memory_arbiter

Overview:
- Shares one synchronous-read, single-port program memory between two requesters: the core instruction fetch port (read-only) and the boot/debug loader port (read/write).
- Sits between the fetch stage, the loader and the memory array.
- Arbitrates per cycle and tracks which requester owns the pending read.
- Supports an exclusive loader lock so a program can be written while the core is stalled.

Parameters:
- MEMORY_DEPTH, 32, number of 32-bit words in the memory.
- DATA_WIDTH, 32, data and byte-address width.
- ADDR_WIDTH, 5, memory word-address width; must equal clog2(MEMORY_DEPTH).

Ports:
- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- fetch_req_i  input  1  fetch read request.
- fetch_addr_i  input  DATA_WIDTH  fetch byte address.
- fetch_gnt_o  output  1  fetch request accepted this cycle.
- fetch_rvalid_o  output  1  fetch read data valid.
- fetch_rdata_o  output  DATA_WIDTH  fetch read data.
- load_req_i  input  1  loader request.
- load_we_i  input  1  loader write enable (1 = write, 0 = read).
- load_addr_i  input  DATA_WIDTH  loader byte address.
- load_wdata_i  input  DATA_WIDTH  loader write data.
- load_lock_i  input  1  loader requests exclusive ownership.
- load_gnt_o  output  1  loader request accepted this cycle.
- load_rvalid_o  output  1  loader read data valid.
- load_rdata_o  output  DATA_WIDTH  loader read data.
- core_stall_o  output  1  core must hold its PC.
- mem_en_o  output  1  memory access enable.
- mem_we_o  output  1  memory write enable.
- mem_addr_o  output  ADDR_WIDTH  memory word address.
- mem_wdata_o  output  DATA_WIDTH  memory write data.
- mem_rdata_i  input  DATA_WIDTH  memory read data, valid one cycle after mem_en_o with mem_we_o=0.

Behaviour:
- Word address is byte address bits [ADDR_WIDTH+1:2]. Bits [1:0] are ignored and upper bits are truncated, so addresses wrap modulo MEMORY_DEPTH.
- FSM states:
  - SHARED: round-robin between the two requesters.
  - LOCK_PEND: lock requested; draining the pending access.
  - LOCKED: loader exclusive.
- Transitions:
  - SHARED→LOCK_PEND when load_lock_i=1.
  - LOCK_PEND→LOCKED when no read is outstanding, which is always true after 1 cycle.
  - LOCKED→SHARED when load_lock_i=0.
  - LOCK_PEND→SHARED if load_lock_i drops before LOCKED is reached.
- Grants:
  - Grants are combinational in the same cycle as the request. At most one grant per cycle.
  - mem_en_o = fetch_gnt_o | load_gnt_o.
  - mem_we_o = load_gnt_o & load_we_i.
  - Address and data muxes select the granted requester.
- SHARED arbitration:
  - If only one requester is asserting, it is granted.
  - If both assert, grant goes to the one not granted last.
  - A 1-bit last_grant register updates on every grant and resets to "fetch" (so the loader wins the first tie).
- LOCK_PEND and LOCKED: fetch is never granted. The loader is granted on every request.
- core_stall_o = (fetch_req_i & ~fetch_gnt_o) | (state != SHARED).
- Read latency:
  - Exactly 1 cycle: rvalid_o of the granted reader is asserted the cycle after the grant, and rdata_o = mem_rdata_i.
  - An owner register tracks which requester owns the pending read.
  - Writes produce no rvalid.
  - The rdata outputs of the non-owner hold their last value.
- Back-to-back grants are allowed every cycle (full throughput).
- Reset:
  - All rvalid, gnt, mem_en_o, mem_we_o and core_stall_o are 0. rdata outputs and mem_addr_o/mem_wdata_o are 0.
  - state = SHARED, last_grant = fetch.
  - A reset mid-read suppresses the pending rvalid.
- Simultaneous events:
  - load_lock_i rising while both requesters are asserting: the grant in that cycle still follows round-robin (state is still SHARED).
  - A loader write and a fetch read to the same word in the same cycle cannot occur, since only one is granted.

Optional Feature:
- PMEM_ARB_MISALIGN_TRAP_EN:
  - Adds output err_o (1 bit).
  - A granted access with addr[1:0]≠0, or with the upper address bits nonzero (beyond MEMORY_DEPTH), is still granted, but mem_en_o is suppressed for it.
  - Its rvalid is still returned one cycle later with rdata = 0, together with a one-cycle err_o pulse.
  - A misaligned write is dropped.
  - Without the macro: no err_o, and addresses are silently truncated/wrapped.

Decomposition:
- Shared package/header:
  - FSM state encodings (SHARED=2'd0, LOCK_PEND=2'd1, LOCKED=2'd2).
  - Requester ID constants (REQ_FETCH=1'b0, REQ_LOAD=1'b1).
  - Word-address slicing macro.
- One natural sub-module, rr_arbiter_2: 2-input round-robin grant logic with the last_grant register. The FSM, muxing and response tracking stay in the top module.

Test Plan:
- Reset then fetch only: fetch_req_i=1, addr 0x0,0x4,0x8 on consecutive cycles → gnt each cycle; mem_addr_o 0,1,2; rvalid with rom words 0,1,2 one cycle later; core_stall_o=0.
- Contention: both requesters asserted for 4 cycles after reset → grants load, fetch, load, fetch; core_stall_o=1 on the cycles where fetch is not granted.
- Lock and write: assert load_lock_i, write 0xDEADBEEF to 0x10 → no fetch grant while locked; mem_we_o=1, mem_addr_o=4. Release lock, then fetch 0x10 → fetch_rdata_o=0xDEADBEEF.
- Wrap-around: fetch at 0x80 with MEMORY_DEPTH=32 → mem_addr_o=0 (rdata = word 0); with the macro enabled → err_o=1, rdata=0, mem_en_o=0.
- Reset mid-read: grant fetch read, assert reset next cycle → fetch_rvalid_o stays 0; state returns to SHARED.
- Lock dropped in LOCK_PEND: pulse load_lock_i for 1 cycle while fetching → at most one lost fetch grant; SHARED resumes on the next cycle.
